// File: rtl/comp_mult_acc.sv
// Complex product accumulator: sums ACC_LEN consecutive {xr,yr} products into one
// complex result and holds it on a val-rdy output until it is taken.
module comp_mult_acc #(
   parameter int DWIDTH  = 8,
   parameter int ACC_LEN = 4,
   localparam int RW     = 2 * (DWIDTH + 1),
   localparam int AW     = RW + $clog2(ACC_LEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sw_rst,
   input  logic            in_val,
   output logic            in_rdy,
   input  logic [2*RW-1:0] in_data,
   output logic            acc_val,
   input  logic            acc_rdy,
   output logic [2*AW-1:0] acc_data
);

   // state  | meaning
   // ACCUM  | taking products into the running sum, no result pending
   // HOLD   | finished sum presented, waiting for acc_rdy
   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   localparam int           CW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic signed [AW-1:0]  r_xa;
   logic signed [AW-1:0]  r_ya;
   logic                  r_acc_val;

   logic                  w_in_hs;
   logic signed [AW-1:0]  w_xr_ext;
   logic signed [AW-1:0]  w_yr_ext;

   assign w_xr_ext = AW'($signed(in_data[2*RW-1:RW]));
   assign w_yr_ext = AW'($signed(in_data[RW-1:0]));

   // In HOLD the input only opens when the result is being taken this cycle.
   assign in_rdy   = (r_state == ST_ACCUM) | acc_rdy;
   assign w_in_hs  = in_val & in_rdy;
   assign acc_val  = r_acc_val;
   assign acc_data = {r_xa, r_ya};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_ACCUM;
         r_cnt     <= '0;
         r_xa      <= '0;
         r_ya      <= '0;
         r_acc_val <= 1'b0;
      end else if (sw_rst) begin
         r_state   <= ST_ACCUM;
         r_cnt     <= '0;
         r_xa      <= '0;
         r_ya      <= '0;
         r_acc_val <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_in_hs) begin
                  if (r_cnt == '0) begin
                     r_xa <= w_xr_ext;
                     r_ya <= w_yr_ext;
                  end else begin
                     r_xa <= r_xa + w_xr_ext;
                     r_ya <= r_ya + w_yr_ext;
                  end
                  if (r_cnt == LAST) begin
                     r_cnt     <= '0;
                     r_state   <= ST_HOLD;
                     r_acc_val <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (acc_rdy) begin
                  if (w_in_hs) begin
                     // Sample accepted alongside the result opens the next frame.
                     r_xa <= w_xr_ext;
                     r_ya <= w_yr_ext;
                     if (ACC_LEN == 1) begin
                        r_cnt     <= '0;
                        r_state   <= ST_HOLD;
                        r_acc_val <= 1'b1;
                     end else begin
                        r_cnt     <= CW'(1);
                        r_state   <= ST_ACCUM;
                        r_acc_val <= 1'b0;
                     end
                  end else begin
                     r_state   <= ST_ACCUM;
                     r_acc_val <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= ST_ACCUM;
               r_acc_val <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comp_mult_acc.sv
// Directed bench for comp_mult_acc: ACC_LEN=4 main instance plus an ACC_LEN=1 instance
// sharing the same input stream.
module tb_comp_mult_acc;

   localparam int RW  = 18;
   localparam int AW  = 20;
   localparam int AW1 = 18;

   logic              clk;
   logic              rst_n;
   logic              sw_rst;
   logic              in_val;
   logic [2*RW-1:0]   in_data;
   logic              acc_rdy;
   logic              in_rdy;
   logic              acc_val;
   logic [2*AW-1:0]   acc_data;
   logic              in_rdy1;
   logic              acc_val1;
   logic [2*AW1-1:0]  acc_data1;

   int n_chk  = 0;
   int n_pass = 0;
   logic [2*AW-1:0] q_out[$];
   logic watch_rdy = 1'b0;
   int   rdy_low   = 0;

   comp_mult_acc #(.DWIDTH(8), .ACC_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
      .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
      .acc_val(acc_val), .acc_rdy(acc_rdy), .acc_data(acc_data)
   );

   comp_mult_acc #(.DWIDTH(8), .ACC_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
      .in_val(in_val), .in_rdy(in_rdy1), .in_data(in_data),
      .acc_val(acc_val1), .acc_rdy(acc_rdy), .acc_data(acc_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && !sw_rst && acc_val && acc_rdy) q_out.push_back(acc_data);
      if (watch_rdy && !in_rdy) rdy_low++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] sum4(input int x, input int y);
      logic [2*AW-1:0] v;
      v = {AW'(x), AW'(y)};
      return 64'(v);
   endfunction

   function automatic logic [63:0] sum1(input int x, input int y);
      logic [2*AW1-1:0] v;
      v = {AW1'(x), AW1'(y)};
      return 64'(v);
   endfunction

   // Present one sample and return 1ns after the edge where it was accepted.
   task automatic push(input int x, input int y);
      int n;
      n = 0;
      in_val  = 1'b1;
      in_data = {RW'(x), RW'(y)};
      @(negedge clk);
      while (!in_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_timeout", 64'(n < 50), 64'(1));
      @(posedge clk); #1;
      in_val = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      sw_rst  = 1'b0;
      in_val  = 1'b0;
      in_data = '0;
      acc_rdy = 1'b1;
      #12;
      chk("rst_acc_val", 64'(acc_val), 64'(0));
      chk("rst_in_rdy", 64'(in_rdy), 64'(1));
      chk("rst_acc_data", 64'(acc_data), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame
      q_out.delete();
      for (int i = 0; i < 3; i++) push(100, -3);
      chk("t1_val_early", 64'(acc_val), 64'(0));
      push(100, -3);
      chk("t1_val", 64'(acc_val), 64'(1));
      chk("t1_data", 64'(acc_data), sum4(400, -12));
      @(posedge clk); #1;
      chk("t1_val_drop", 64'(acc_val), 64'(0));
      chk("t1_q", 64'(q_out.size()), 64'(1));

      // Extremes
      for (int i = 0; i < 4; i++) push(-131072, 131071);
      chk("t2_data", 64'(acc_data), sum4(-524288, 524284));
      @(posedge clk); #1;

      // Backpressure
      q_out.delete();
      acc_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push(1, 2);
      in_val  = 1'b1;
      in_data = {RW'(5), RW'(6)};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_val", 64'(acc_val), 64'(1));
         chk("t3_hold_data", 64'(acc_data), sum4(4, 8));
         chk("t3_hold_rdy", 64'(in_rdy), 64'(0));
      end
      @(posedge clk); #1;
      acc_rdy = 1'b1;
      for (int i = 0; i < 4; i++) push(5, 6);
      chk("t3_next", 64'(acc_data), sum4(20, 24));
      chk("t3_first", 64'(q_out.size() > 0 ? q_out[0] : '0), sum4(4, 8));
      @(posedge clk); #1;

      // Chaining
      q_out.delete();
      rdy_low   = 0;
      watch_rdy = 1'b1;
      for (int k = 1; k <= 12; k++) push(k, k);
      watch_rdy = 1'b0;
      @(posedge clk); #1;
      chk("t4_count", 64'(q_out.size()), 64'(3));
      if (q_out.size() == 3) begin
         chk("t4_sum0", 64'(q_out[0]), sum4(10, 10));
         chk("t4_sum1", 64'(q_out[1]), sum4(26, 26));
         chk("t4_sum2", 64'(q_out[2]), sum4(42, 42));
      end
      chk("t4_rdy_low", 64'(rdy_low), 64'(0));

      // sw_rst mid-frame
      push(7, 7);
      push(7, 7);
      sw_rst  = 1'b1;
      in_val  = 1'b1;
      in_data = {RW'(9), RW'(9)};
      @(posedge clk); #1;
      sw_rst = 1'b0;
      in_val = 1'b0;
      chk("t5_clr_data", 64'(acc_data), 64'(0));
      chk("t5_clr_val", 64'(acc_val), 64'(0));
      for (int i = 0; i < 4; i++) push(1, 1);
      chk("t5_data", 64'(acc_data), sum4(4, 4));
      @(posedge clk); #1;

      // Async reset while holding
      acc_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push(3, 3);
      chk("t6_hold", 64'(acc_val), 64'(1));
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_val", 64'(acc_val), 64'(0));
      chk("t6_async_data", 64'(acc_data), 64'(0));
      chk("t6_async_rdy", 64'(in_rdy), 64'(1));
      @(negedge clk);
      rst_n   = 1'b1;
      acc_rdy = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push(2, -1);
      chk("t6_after", 64'(acc_data), sum4(8, -4));
      @(posedge clk); #1;

      // ACC_LEN=1 pass-through
      push(-5, 7);
      chk("l1_val0", 64'(acc_val1), 64'(1));
      chk("l1_data0", 64'(acc_data1), sum1(-5, 7));
      push(-131072, 131071);
      chk("l1_val1", 64'(acc_val1), 64'(1));
      chk("l1_data1", 64'(acc_data1), sum1(-131072, 131071));
      push(0, -1);
      chk("l1_data2", 64'(acc_data1), sum1(0, -1));
      @(posedge clk); #1;
      chk("l1_drop", 64'(acc_val1), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
